// File: rtl/pipeexe_stage.sv
// rtl/pipeexe_stage.sv - ID/EX pipeline register and execute stage of the 5-stage MIPS pipeline
//
// Ports:
//   clk, clrn            clock, asynchronous active-low reset
//   nostall              0 = decode stalling, capture a bubble
//   wreg, m2reg, wmem    decode controls
//   aluc, aluimm, shift  ALU op and operand selects
//   jal                  jump-and-link
//   a, b, imm, rn, dpc4  operands, immediate, destination register, PC+4
//   ewreg, em2reg, ewmem E-stage controls (ewreg/ewmem gated by ~ebusy)
//   ern, ealu, eb        E-stage destination, result, store data
//   ebusy                E occupied by a multi-cycle op
//
// Optional feature macro: PIPEEXE_MUL_EN (iterative 32-cycle shift-add multiplier
// on aluc=1011). Without it aluc=1011 returns 0 and ebusy is tied low.

module pipeexe_stage #(
    parameter int JAL_RN = 31
`ifdef PIPEEXE_MUL_EN
    , parameter int MUL_CYCLES = 32
`endif
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        nostall,
    input  logic        wreg,
    input  logic        m2reg,
    input  logic        wmem,
    input  logic [3:0]  aluc,
    input  logic        aluimm,
    input  logic        shift,
    input  logic        jal,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] imm,
    input  logic [4:0]  rn,
    input  logic [31:0] dpc4,
    output logic        ewreg,
    output logic        em2reg,
    output logic        ewmem,
    output logic [4:0]  ern,
    output logic [31:0] ealu,
    output logic [31:0] eb,
    output logic        ebusy
);

    localparam logic [3:0] ALUC_MUL = 4'b1011;

    logic        ewreg_q;
    logic        ewmem_q;
    logic        ealuimm;
    logic        eshift;
    logic        ejal;
    logic [3:0]  ealuc;
    logic [4:0]  ern_q;
    logic [31:0] ea;
    logic [31:0] eimm;
    logic [31:0] epc4;

    // ID/EX register: hold while busy (hold beats bubble), bubble on stall.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ewreg_q <= 1'b0;
            em2reg  <= 1'b0;
            ewmem_q <= 1'b0;
            ealuc   <= 4'd0;
            ealuimm <= 1'b0;
            eshift  <= 1'b0;
            ejal    <= 1'b0;
            ea      <= 32'd0;
            eb      <= 32'd0;
            eimm    <= 32'd0;
            ern_q   <= 5'd0;
            epc4    <= 32'd0;
        end else if (!ebusy) begin
            if (!nostall) begin
                ewreg_q <= 1'b0;
                em2reg  <= 1'b0;
                ewmem_q <= 1'b0;
                ealuc   <= 4'd0;
                ealuimm <= 1'b0;
                eshift  <= 1'b0;
                ejal    <= 1'b0;
                ea      <= 32'd0;
                eb      <= 32'd0;
                eimm    <= 32'd0;
                ern_q   <= 5'd0;
                epc4    <= 32'd0;
            end else begin
                ewreg_q <= wreg;
                em2reg  <= m2reg;
                ewmem_q <= wmem;
                ealuc   <= aluc;
                ealuimm <= aluimm;
                eshift  <= shift;
                ejal    <= jal;
                ea      <= a;
                eb      <= b;
                eimm    <= imm;
                ern_q   <= rn;
                epc4    <= dpc4;
            end
        end
    end

    logic [31:0] alua;
    logic [31:0] alub;
    logic [31:0] alu_res;
    logic [31:0] mul_res;

    // Shift amount comes from the shamt field, which sits in imm[10:6].
    assign alua = eshift ? {27'd0, eimm[10:6]} : ea;
    assign alub = ealuimm ? eimm : eb;

    always_comb begin
        alu_res = 32'd0;
        casez (ealuc)
            4'b?000: alu_res = alua + alub;
            4'b?100: alu_res = alua - alub;
            4'b?001: alu_res = alua & alub;
            4'b?101: alu_res = alua | alub;
            4'b?010: alu_res = alua ^ alub;
            4'b?110: alu_res = {alub[15:0], 16'd0};
            4'b0011: alu_res = alub << alua[4:0];
            4'b0111: alu_res = alub >> alua[4:0];
            4'b1111: alu_res = 32'($signed(alub) >>> alua[4:0]);
            ALUC_MUL: alu_res = mul_res;
            default: alu_res = 32'd0;
        endcase
    end

    // jal links PC+8, i.e. the decode-stage PC+4 plus one more word.
    assign ealu  = ejal ? (epc4 + 32'd4) : alu_res;
    assign ern   = ejal ? 5'(JAL_RN) : ern_q;
    assign ewreg = ewreg_q & ~ebusy;
    assign ewmem = ewmem_q & ~ebusy;

`ifdef PIPEEXE_MUL_EN
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] product;
    logic [5:0]  cnt;

    // Only the low 32 product bits are kept, so a 32-bit multiplicand suffices.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= S_IDLE;
            mcand   <= 32'd0;
            mplier  <= 32'd0;
            product <= 32'd0;
            cnt     <= 6'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ealuc == ALUC_MUL) begin
                        state   <= S_RUN;
                        mcand   <= ea;
                        mplier  <= alub;
                        product <= 32'd0;
                        cnt     <= 6'd0;
                    end
                end
                S_RUN: begin
                    if (mplier[0]) begin
                        product <= product + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 6'd1;
                    if (cnt == 6'(MUL_CYCLES - 1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Busy from the first cycle the MUL sits in E; DONE releases the pipeline.
    assign ebusy   = (state == S_RUN) || ((state == S_IDLE) && (ealuc == ALUC_MUL));
    assign mul_res = product;
`else
    assign ebusy   = 1'b0;
    assign mul_res = 32'd0;
`endif

endmodule
